op_unit_scheduler: RTL

- Shares one 5-bit operator datapath between two requesters.
- Operators: equality, reduction-OR, greater-than, logical-AND, bitwise-AND, shift-left-2, variable shift-right, and conditional add/sub.
- A round-robin arbiter grants one request at a time. An FSM sequences execution, including a multi-cycle iterative shift-right.
- The result is held on a valid/ready response channel tagged with the requester ID.

---
 rtl/op_unit_scheduler_pkg.sv | 21 ++
 rtl/op_unit_comb.sv | 33 +++
 rtl/op_unit_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/op_unit_scheduler_pkg.sv
// rtl/op_unit_scheduler_pkg.sv - shared width, opcodes and FSM states for op_unit_scheduler
package op_unit_scheduler_pkg;

    localparam int W_DEFAULT = 5;

    localparam logic [2:0] OP_EQ   = 3'd0;
    localparam logic [2:0] OP_ORB  = 3'd1;
    localparam logic [2:0] OP_GT   = 3'd2;
    localparam logic [2:0] OP_LAND = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_SHL2 = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_CAS  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/op_unit_comb.sv
// rtl/op_unit_comb.sv - single-cycle operators (all opcodes except the iterative SHR)
module op_unit_comb
    import op_unit_scheduler_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   result
);

    logic [W:0] a_x;
    logic [W:0] b_x;

    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};

    always_comb begin
        result = '0;
        case (op)
            OP_EQ:   result = {{W{1'b0}}, a == b};
            OP_ORB:  result = {{W{1'b0}}, |b};
            OP_GT:   result = {{W{1'b0}}, a > b};
            OP_LAND: result = {{W{1'b0}}, (|a) && (|b)};
            OP_AND:  result = a_x & b_x;
            OP_SHL2: result = a_x << 2;
            OP_CAS:  result = (a > b) ? (a_x + b_x) : (a_x - b_x);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/op_unit_scheduler.sv
// rtl/op_unit_scheduler.sv - round-robin shared operator unit with iterative shift-right
module op_unit_scheduler
    import op_unit_scheduler_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W:0]   rsp_data,
    output logic         rsp_id
);

    localparam int CW = $clog2(W + 1);

    state_t         state;
    state_t         state_nxt;
    logic           last_grant;
    logic           grant_id;
    logic           xfer;
    logic           is_shr;
    logic [2:0]     sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   sh_reg;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  shamt;
    logic [W:0]     comb_result;

    // On contention the requester that was not granted last wins.
    assign grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign sel_op   = grant_id ? req1_op : req0_op;
    assign sel_a    = grant_id ? req1_a  : req0_a;
    assign sel_b    = grant_id ? req1_b  : req0_b;
    assign xfer     = (state == ST_IDLE) && (req0_valid || req1_valid);
    assign is_shr   = (sel_op == OP_SHR);
    assign shamt    = (sel_b >= W'(W)) ? CW'(W) : CW'(sel_b);

    op_unit_comb #(.W(W)) u_comb (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (comb_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_nxt = (is_shr && (shamt != '0)) ? ST_SHIFT : ST_RESP;
                end
            end
            ST_SHIFT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Readies are masked during reset so nothing looks accepted while the core is held.
    always_comb begin
        rsp_valid  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = rst_n && req0_valid && !grant_id;
                req1_ready = rst_n && req1_valid && grant_id;
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            sh_reg     <= '0;
            cnt        <= '0;
        end else begin
            if (xfer) begin
                last_grant <= grant_id;
                rsp_id     <= grant_id;
                if (is_shr) begin
                    sh_reg <= sel_a;
                    cnt    <= shamt;
                    if (shamt == '0) begin
                        rsp_data <= {1'b0, sel_a};
                    end
                end else begin
                    rsp_data <= comb_result;
                end
            end else if (state == ST_SHIFT) begin
                sh_reg <= sh_reg >> 1;
                cnt    <= cnt - CW'(1);
                // The last shift lands directly in the response register.
                if (cnt == CW'(1)) begin
                    rsp_data <= {1'b0, sh_reg >> 1};
                end
            end
        end
    end

endmodule
